// File: rtl/neuron_mac.sv
// Streamed multi-input neuron: y = act(round(bias + sum x*w)) with valid/ready handshakes,
// a one-stage multiply pipeline, saturating accumulation and vector-length checking.
module neuron_mac #(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned ACC_W     = 20,
    parameter bit          RELU_EN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] in_bias,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    output logic                     out_len_err
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W1 = ACC_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0]   HALF     = ACC_W1'(2 ** (FRAC_BITS - 1));
    localparam logic signed [ACC_W:0]   OUT_MAX  = ACC_W1'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W:0]   OUT_MIN  = ~OUT_MAX;
    localparam logic [DATA_W-1:0]       D_MAX    = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]       D_MIN    = {1'b1, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StResult} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod_reg;
    logic                     prod_vld;
    logic [CNT_W-1:0]         cnt;
    logic                     sat_flag;
    logic                     len_err_flag;
    logic                     valid_reg;

    logic signed [PROD_W-1:0] prod_next;
    logic signed [ACC_W-1:0]  bias_aligned;
    logic signed [ACC_W:0]    sum_wide;
    logic                     sum_clip;
    logic signed [ACC_W-1:0]  sum_sat;
    logic signed [ACC_W:0]    rnd_wide;
    logic signed [ACC_W:0]    r_shift;
    logic signed [ACC_W:0]    r_act;
    logic                     out_clip;

    assign prod_next    = PROD_W'(in_x) * PROD_W'(in_w);
    assign bias_aligned = ACC_W'(in_bias) <<< FRAC_BITS;

    // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
    assign sum_wide = ACC_W1'(acc) + ACC_W1'(prod_reg);
    assign sum_clip = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    assign sum_sat  = sum_clip ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];

    // Round half toward +inf, optional ReLU, then clip into the output range.
    assign rnd_wide = ACC_W1'(acc) + HALF;
    assign r_shift  = rnd_wide >>> FRAC_BITS;
    assign r_act    = (RELU_EN && r_shift[ACC_W]) ? '0 : r_shift;
    assign out_clip = (r_act > OUT_MAX) || (r_act < OUT_MIN);

    always_comb begin
        out_data = r_act[DATA_W-1:0];
        if (out_clip) begin
            out_data = r_act[ACC_W] ? D_MIN : D_MAX;
        end
    end

    assign in_ready    = (state == StIdle) || (state == StAccum);
    assign out_valid   = valid_reg;
    assign out_sat     = valid_reg && (sat_flag || out_clip);
    assign out_len_err = valid_reg && len_err_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            acc          <= '0;
            prod_reg     <= '0;
            prod_vld     <= 1'b0;
            cnt          <= '0;
            sat_flag     <= 1'b0;
            len_err_flag <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        acc          <= bias_aligned;
                        cnt          <= CNT_W'(1);
                        prod_reg     <= prod_next;
                        prod_vld     <= 1'b1;
                        sat_flag     <= 1'b0;
                        len_err_flag <= (N_INPUTS == 1) && !in_last;
                        state        <= (in_last || N_INPUTS == 1) ? StFlush : StAccum;
                    end
                end
                StAccum: begin
                    if (prod_vld) begin
                        acc <= sum_sat;
                        if (sum_clip) sat_flag <= 1'b1;
                    end
                    prod_vld <= in_valid;
                    if (in_valid) begin
                        prod_reg <= prod_next;
                        cnt      <= cnt + CNT_W'(1);
                        if (in_last || cnt == CNT_LAST) begin
                            state <= StFlush;
                            if (!in_last) len_err_flag <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (prod_vld) begin
                        acc <= sum_sat;
                        if (sum_clip) sat_flag <= 1'b1;
                    end
                    prod_vld  <= 1'b0;
                    valid_reg <= 1'b1;
                    state     <= StResult;
                end
                StResult: begin
                    if (out_ready) begin
                        valid_reg    <= 1'b0;
                        sat_flag     <= 1'b0;
                        len_err_flag <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: ReLU and linear instances share stimulus and are checked
// every cycle against an arithmetic model, plus literal expectations per vector.
module tb_neuron_mac;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int F   = 4;
    localparam int AW  = 20;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW - 1));

    typedef int vec_t[4];
    typedef struct {
        int d_r; bit s_r;
        int d_l; bit s_l;
        bit le;
        int t_last;
        int lit_r; int lit_l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic signed [DW-1:0] in_x, in_w, in_bias;
    logic in_ready_r, out_valid_r, out_sat_r, out_len_err_r;
    logic in_ready_l, out_valid_l, out_sat_l, out_len_err_l;
    logic signed [DW-1:0] out_data_r, out_data_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -1;
    bit seen = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(F), .ACC_W(AW), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_x(in_x),
        .in_w(in_w), .in_bias(in_bias), .in_last(in_last), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_data(out_data_r), .out_sat(out_sat_r),
        .out_len_err(out_len_err_r)
    );

    neuron_mac #(.N_INPUTS(N), .DATA_W(DW), .FRAC_BITS(F), .ACC_W(AW), .RELU_EN(1'b0)) u_lin (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_x(in_x),
        .in_w(in_w), .in_bias(in_bias), .in_last(in_last), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_data(out_data_l), .out_sat(out_sat_l),
        .out_len_err(out_len_err_l)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain arithmetic: bias in Q(2F), clamped running sum, round half up, act, clip.
    task automatic model(input int bias, input vec_t xs, input vec_t ws, input int nb,
                         input bit relu, output int d, output bit s);
        longint acc;
        longint r;
        s = 1'b0;
        acc = longint'(bias) * (64'sd1 <<< F);
        for (int i = 0; i < nb; i++) begin
            acc = acc + longint'(xs[i]) * longint'(ws[i]);
            if (acc > AMAX) begin acc = AMAX; s = 1'b1; end
            if (acc < AMIN) begin acc = AMIN; s = 1'b1; end
        end
        r = (acc + (64'sd1 <<< (F - 1))) >>> F;
        if (relu && r < 0) r = 0;
        if (r > 127) begin r = 127; s = 1'b1; end
        if (r < -128) begin r = -128; s = 1'b1; end
        d = int'(r);
    endtask

    task automatic beat(input int x, input int w, input int b, input bit last, output int t);
        int n = 0;
        bit ok = 1'b0;
        in_x = DW'(x); in_w = DW'(w); in_bias = DW'(b); in_last = last; in_valid = 1'b1;
        t = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready_r;
            t = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_vec(input int bias, input vec_t xs, input vec_t ws, input int nb,
                            input bit with_last, input int lit_r, input int lit_l,
                            output int t_first);
        exp_t x;
        int t;
        for (int i = 0; i < nb; i++) begin
            // Bias on later beats is garbage; only the first beat's bias may matter.
            beat(xs[i], ws[i], (i == 0) ? bias : (bias ^ 8'h5a), with_last && (i == nb - 1), t);
            if (i == 0) t_first = t;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        model(bias, xs, ws, nb, 1'b1, x.d_r, x.s_r);
        model(bias, xs, ws, nb, 1'b0, x.d_l, x.s_l);
        x.le     = (nb == N) && !with_last;
        x.t_last = t;
        x.lit_r  = lit_r;
        x.lit_l  = lit_l;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_r !== out_valid_l) chk("valid_agree", int'(out_valid_l), int'(out_valid_r));
            if (in_ready_r !== in_ready_l) chk("ready_agree", int'(in_ready_l), int'(in_ready_r));
            if (out_valid_r) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("data_relu", int'(out_data_r), e.d_r);
                    chk("sat_relu", int'(out_sat_r), int'(e.s_r));
                    chk("data_lin", int'(out_data_l), e.d_l);
                    chk("sat_lin", int'(out_sat_l), int'(e.s_l));
                    chk("len_err", int'(out_len_err_r), int'(e.le));
                    chk("len_err_lin", int'(out_len_err_l), int'(e.le));
                    chk("ready_in_result", int'(in_ready_r), 0);
                    if (!seen) begin
                        chk("latency", cyc, e.t_last + 2);
                        chk("literal_relu", int'(out_data_r), e.lit_r);
                        chk("literal_lin", int'(out_data_l), e.lit_l);
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        hs_cyc = cyc;
                        seen = 1'b0;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t0, n;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_x = '0; in_w = '0; in_bias = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid_r), 0);
        chk("rst_out_data", int'(out_data_r), 0);
        chk("rst_out_sat", int'(out_sat_r), 0);
        chk("rst_len_err", int'(out_len_err_r), 0);
        chk("rst_in_ready", int'(in_ready_r), 1);
        @(posedge clk); #1;

        send_vec(8, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 4, 1'b1, 72, 72, t0);
        send_vec(0, '{127, 127, 127, 127}, '{127, 127, 127, 127}, 4, 1'b1, 127, 127, t0);
        send_vec(0, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, 4, 1'b1, 0, -128, t0);
        send_vec(0, '{-16, -16, -16, -16}, '{16, 16, 16, 16}, 4, 1'b1, 0, -64, t0);
        send_vec(0, '{1, 0, 0, 0}, '{8, 0, 0, 0}, 1, 1'b1, 1, 1, t0);
        send_vec(0, '{1, 0, 0, 0}, '{7, 0, 0, 0}, 1, 1'b1, 0, 0, t0);
        send_vec(0, '{-1, 0, 0, 0}, '{8, 0, 0, 0}, 1, 1'b1, 0, 0, t0);
        send_vec(0, '{16, 16, 0, 0}, '{16, 16, 0, 0}, 2, 1'b1, 32, 32, t0);

        // Overlong vector: a fifth beat is offered and must stall through FLUSH and RESULT.
        send_vec(0, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 4, 1'b0, 64, 64, t0);
        in_x = 8'sd16; in_w = 8'sd16; in_valid = 1'b1;
        @(negedge clk); chk("fifth_stall_flush", int'(in_ready_r), 0);
        @(negedge clk); chk("fifth_stall_result", int'(in_ready_r), 0);
        @(posedge clk); #1 in_valid = 1'b0;

        // Backpressure: hold result 5 cycles, then a waiting vector must enter right after.
        out_ready = 1'b0;
        send_vec(8, '{16, 16, 16, 16}, '{16, 16, 16, 16}, 4, 1'b1, 72, 72, t0);
        n = 0;
        while (!out_valid_r && n < 10) begin @(negedge clk); n++; end
        chk("bp_valid_seen", int'(out_valid_r), 1);
        in_x = 8'sd1; in_w = 8'sd8; in_bias = '0; in_last = 1'b1; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        send_vec(0, '{1, 0, 0, 0}, '{8, 0, 0, 0}, 1, 1'b1, 1, 1, t0);
        chk("back_to_back", t0, hs_cyc + 1);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-vector: nothing emitted, next vector clean.
        beat(16, 16, 0, 1'b0, t);
        beat(16, 16, 0, 1'b0, t);
        in_x = 8'sd16; in_w = 8'sd16; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(out_valid_r), 0);
        chk("abort_in_ready", int'(in_ready_r), 1);
        @(posedge clk); #1;
        send_vec(16, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 1'b1, 16, 16, t0);

        repeat (6) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
